// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART command dispatcher.
// Holds the dispatcher state enum, default response bytes, frame lengths
// and the frame checksum helper.
package cmd_pkg;

    // Dispatcher states; GOT_DATA exists only when frames carry a checksum
`ifdef CMD_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_ID,
        S_GOT_ADDR,
        S_GOT_DATA,
        S_ACK
    } disp_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_ID,
        S_GOT_ADDR,
        S_ACK
    } disp_state_t;
`endif

    localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
    localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

    localparam int unsigned FRAME_LEN_BASE = 3;
    localparam int unsigned FRAME_LEN_CHK  = 4;
`ifdef CMD_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = FRAME_LEN_CHK;
`else
    localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif

    // Checksum byte carried as the 4th frame byte
    function automatic logic [7:0] frame_chk(input logic [7:0] id,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return id ^ addr ^ data;
    endfunction

endpackage

// File: rtl/rx_byte_strobe.sv
// Turns the receiver's byte-valid level into a one-cycle byte event.
// Ports:
//   clk, reset   - clock, synchronous active-low reset
//   rx_ready     - receiver byte-valid level (may stay high many cycles)
//   rx_data      - received byte, valid while rx_ready is high
//   byte_valid_c - high for the single cycle in which rx_ready rises
//   byte_c       - received byte during byte_valid_c, zero otherwise
module rx_byte_strobe (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       byte_valid_c,
    output logic [7:0] byte_c
);

    logic rx_ready_q;

    // Previous-cycle copy of rx_ready for rising-edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_ready_q <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
        end
    end

    assign byte_valid_c = rx_ready & ~rx_ready_q;
    assign byte_c       = byte_valid_c ? rx_data : 8'h00;

endmodule

// File: rtl/uart_cmd_dispatcher.sv
// Frames the host UART byte stream into register-write commands
// ([id][addr][data], plus [id^addr^data] when CMD_CHECKSUM_EN is defined),
// pulses a one-hot write to the addressed module and answers with ACK/NAK.
// Ports:
//   clk, reset         - clock, synchronous active-low reset
//   Rx_ready, Rx_data  - receiver byte-valid level and byte
//   Tx_busy            - transmitter busy
//   Tx_start, Tx_data  - one-cycle transmit request and held response byte
//   wr_en              - one-cycle register write strobe
//   wr_sel             - one-hot target module, non-zero only with wr_en
//   wr_addr, wr_data   - register address/data of the last write (held)
//   busy               - dispatcher is not idle
//   overrun            - sticky: a byte arrived while a response was pending
module uart_cmd_dispatcher
    import cmd_pkg::*;
#(
    parameter int unsigned N_MOD       = 4,
    parameter logic [7:0]  ID_BASE     = 8'h10,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  ACK_BYTE    = ACK_BYTE_DEF,
    parameter logic [7:0]  NAK_BYTE    = NAK_BYTE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Rx_ready,
    input  logic [7:0]       Rx_data,
    input  logic             Tx_busy,
    output logic             Tx_start,
    output logic [7:0]       Tx_data,
    output logic             wr_en,
    output logic [N_MOD-1:0] wr_sel,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy,
    output logic             overrun
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    disp_state_t      state;
    logic             byte_valid_c;
    logic [7:0]       byte_c;
    logic [CNT_W-1:0] tmo_cnt;
    logic [N_MOD-1:0] sel_q;
    logic [7:0]       addr_q;
    logic [7:0]       id_off_c;
    logic             id_hit_c;
    logic             tmo_hit_c;
    logic             collecting_c;
    logic             nak_q;

`ifdef CMD_CHECKSUM_EN
    logic [7:0] id_q;
    logic [7:0] data_q;
`else
    assign nak_q = 1'b0;
`endif

    rx_byte_strobe u_rx_strobe (
        .clk          (clk),
        .reset        (reset),
        .rx_ready     (Rx_ready),
        .rx_data      (Rx_data),
        .byte_valid_c (byte_valid_c),
        .byte_c       (byte_c)
    );

    assign id_off_c     = byte_c - ID_BASE;
    assign id_hit_c     = (byte_c >= ID_BASE) && (32'(id_off_c) < N_MOD);
    assign tmo_hit_c    = (tmo_cnt == TMO_LAST);
    assign collecting_c = (state != S_IDLE) && (state != S_ACK);
    assign busy         = (state != S_IDLE);

    // Frame parser, write strobe, response and inter-byte timeout
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            tmo_cnt  <= '0;
            sel_q    <= '0;
            addr_q   <= 8'h00;
            Tx_start <= 1'b0;
            Tx_data  <= 8'h00;
            wr_en    <= 1'b0;
            wr_sel   <= '0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            overrun  <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            id_q     <= 8'h00;
            data_q   <= 8'h00;
            nak_q    <= 1'b0;
`endif
        end else begin
            wr_en    <= 1'b0;
            wr_sel   <= '0;
            Tx_start <= 1'b0;

            // Counter only runs mid-frame; a byte beats a same-cycle expiry
            if (collecting_c && !byte_valid_c && !tmo_hit_c) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (byte_valid_c && id_hit_c) begin
                        sel_q <= N_MOD'(1) << id_off_c;
`ifdef CMD_CHECKSUM_EN
                        id_q  <= byte_c;
`endif
                        state <= S_GOT_ID;
                    end
                end
                S_GOT_ID: begin
                    if (byte_valid_c) begin
                        addr_q <= byte_c;
                        state  <= S_GOT_ADDR;
                    end else if (tmo_hit_c) begin
                        state <= S_IDLE;
                    end
                end
                S_GOT_ADDR: begin
                    if (byte_valid_c) begin
`ifdef CMD_CHECKSUM_EN
                        data_q <= byte_c;
                        state  <= S_GOT_DATA;
`else
                        wr_en   <= 1'b1;
                        wr_sel  <= sel_q;
                        wr_addr <= addr_q;
                        wr_data <= byte_c;
                        state   <= S_ACK;
`endif
                    end else if (tmo_hit_c) begin
                        state <= S_IDLE;
                    end
                end
`ifdef CMD_CHECKSUM_EN
                S_GOT_DATA: begin
                    if (byte_valid_c) begin
                        if (byte_c == frame_chk(id_q, addr_q, data_q)) begin
                            wr_en   <= 1'b1;
                            wr_sel  <= sel_q;
                            wr_addr <= addr_q;
                            wr_data <= data_q;
                            nak_q   <= 1'b0;
                        end else begin
                            nak_q <= 1'b1;
                        end
                        state <= S_ACK;
                    end else if (tmo_hit_c) begin
                        state <= S_IDLE;
                    end
                end
`endif
                S_ACK: begin
                    // No timeout here: the response waits for the transmitter
                    if (byte_valid_c) begin
                        overrun <= 1'b1;
                    end
                    if (!Tx_busy) begin
                        Tx_start <= 1'b1;
                        Tx_data  <= nak_q ? NAK_BYTE : ACK_BYTE;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_dispatcher.sv
// Self-checking bench for uart_cmd_dispatcher: table-driven frames with
// cycle-exact checks, hand-written timeout/busy/reset sequences and a
// randomized byte stream compared against a queue-based frame model.
module tb_uart_cmd_dispatcher;
    import cmd_pkg::*;

    localparam int unsigned N_MOD = 4;
    localparam logic [7:0]  IDB   = 8'h10;
    localparam int unsigned TMO   = 16;
    localparam int          NV    = 6;

    logic             clk;
    logic             reset;
    logic             Rx_ready;
    logic [7:0]       Rx_data;
    logic             Tx_busy;
    logic             Tx_start;
    logic [7:0]       Tx_data;
    logic             wr_en;
    logic [N_MOD-1:0] wr_sel;
    logic [7:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             busy;
    logic             overrun;

    uart_cmd_dispatcher #(
        .N_MOD       (N_MOD),
        .ID_BASE     (IDB),
        .TIMEOUT_CYC (TMO),
        .ACK_BYTE    (8'h06),
        .NAK_BYTE    (8'h15)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Rx_ready (Rx_ready),
        .Rx_data  (Rx_data),
        .Tx_busy  (Tx_busy),
        .Tx_start (Tx_start),
        .Tx_data  (Tx_data),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic       has_junk;
        logic [7:0] junk;
        logic [7:0] id;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] chk;
        logic       exp_wr;
        logic [3:0] sel;
        logic [7:0] tx;
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   sel_glitch = 0;
    wr_t  wr_log[$];
    logic [7:0] tx_log[$];
    wr_t  exp_wr_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] mf[$];
    int   gap_since = 1000;
    vec_t tbl[NV];

    // Collect every write and transmit request; wr_sel must be 0 without wr_en
    always @(negedge clk) begin
        if (wr_en) wr_log.push_back('{sel: wr_sel, addr: wr_addr, data: wr_data});
        if (Tx_start) tx_log.push_back(Tx_data);
        if (!wr_en && wr_sel != '0) sel_glitch++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int low);
        Rx_data  = b;
        Rx_ready = 1'b1;
        tick(hold);
        Rx_ready = 1'b0;
        Rx_data  = 8'($urandom);
        tick(low);
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [7:0] addr, input logic [7:0] data);
        send_byte(id, 1, 1);
        send_byte(addr, 1, 1);
        send_byte(data, 1, 1);
`ifdef CMD_CHECKSUM_EN
        send_byte(id ^ addr ^ data, 1, 1);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_sel"}, 32'(wr_sel), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_tx_start"}, 32'(Tx_start), 0);
        check({tag, "_tx_data"}, 32'(Tx_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    // Drive one table vector and check the write/response cycle by cycle
    task automatic apply_vec(input vec_t v);
        logic [7:0] fb[4];
        int n0, t0;
        n0 = wr_log.size();
        t0 = tx_log.size();
        if (v.has_junk) begin
            send_byte(v.junk, 1, 2);
            tick(2);
            check("junk_no_wr", 32'(wr_log.size()), 32'(n0));
            check("junk_no_tx", 32'(tx_log.size()), 32'(t0));
            check("junk_idle", 32'(busy), 0);
        end
        fb[0] = v.id; fb[1] = v.addr; fb[2] = v.data; fb[3] = v.chk;
        for (int i = 0; i < int'(FRAME_LEN) - 1; i++)
            send_byte(fb[i], 1 + int'($urandom_range(0, 1)), 1 + int'($urandom_range(0, 1)));
        Rx_data  = fb[FRAME_LEN-1];
        Rx_ready = 1'b1;
        @(negedge clk);
        check("wr_not_early", 32'(wr_en), 0);
        @(negedge clk);
        check("wr_en", 32'(wr_en), 32'(v.exp_wr));
        check("busy_in_ack", 32'(busy), 1);
        if (v.exp_wr) begin
            check("wr_sel", 32'(wr_sel), 32'(v.sel));
            check("wr_addr", 32'(wr_addr), 32'(v.addr));
            check("wr_data", 32'(wr_data), 32'(v.data));
        end
        @(negedge clk);
        check("wr_en_one_cycle", 32'(wr_en), 0);
        check("tx_start", 32'(Tx_start), 1);
        check("tx_data", 32'(Tx_data), 32'(v.tx));
        check("busy_after", 32'(busy), 0);
        if (v.exp_wr) begin
            check("wr_addr_hold", 32'(wr_addr), 32'(v.addr));
            check("wr_data_hold", 32'(wr_data), 32'(v.data));
        end
        @(negedge clk);
        check("tx_start_one_cycle", 32'(Tx_start), 0);
        @(posedge clk);
        #1;
        Rx_ready = 1'b0;
        Rx_data  = 8'($urandom);
        tick(2);
        check("long_ready_one_write", 32'(wr_log.size()), 32'(n0 + int'(v.exp_wr)));
        check("long_ready_one_tx", 32'(tx_log.size()), 32'(t0 + 1));
    endtask

    // Frame-level reference: collect bytes, drop stale partial frames
    task automatic model_byte(input logic [7:0] b, input int gap);
        logic ok;
        if (mf.size() > 0 && gap > int'(TMO)) mf.delete();
        if (mf.size() == 0) begin
            if (int'(b) >= int'(IDB) && int'(b) < int'(IDB) + int'(N_MOD)) mf.push_back(b);
        end else begin
            mf.push_back(b);
            if (mf.size() == int'(FRAME_LEN)) begin
`ifdef CMD_CHECKSUM_EN
                ok = (mf[3] == (mf[0] ^ mf[1] ^ mf[2]));
`else
                ok = 1'b1;
`endif
                if (ok) exp_wr_q.push_back('{sel: 4'(1 << (mf[0] - IDB)), addr: mf[1], data: mf[2]});
                exp_tx_q.push_back(ok ? 8'h06 : 8'h15);
                mf.delete();
            end
        end
    endtask

    task automatic mbyte(input logic [7:0] b, input int hold, input int low);
        model_byte(b, gap_since);
        send_byte(b, hold, low);
        gap_since = hold + low;
    endtask

    initial begin
        int n0, t0;
        logic seen;
        logic [7:0] b;
        Rx_ready = 1'b0;
        Rx_data  = 8'h00;
        Tx_busy  = 1'b0;
        reset    = 1'b0;

        tbl[0] = '{1'b0, 8'h00, 8'h12, 8'h03, 8'hA5, 8'hB4, 1'b1, 4'b0100, 8'h06};
        tbl[1] = '{1'b1, 8'h7F, 8'h10, 8'h01, 8'h02, 8'h13, 1'b1, 4'b0001, 8'h06};
        tbl[2] = '{1'b1, 8'h14, 8'h13, 8'h07, 8'h55, 8'h41, 1'b1, 4'b1000, 8'h06};
        tbl[3] = '{1'b1, 8'h0F, 8'h11, 8'hFF, 8'h00, 8'hEE, 1'b1, 4'b0010, 8'h06};
        tbl[4] = '{1'b0, 8'h00, 8'h11, 8'h05, 8'h09, 8'h1D, 1'b1, 4'b0010, 8'h06};
`ifdef CMD_CHECKSUM_EN
        tbl[5] = '{1'b0, 8'h00, 8'h10, 8'h01, 8'h02, 8'h00, 1'b0, 4'b0000, 8'h15};
`else
        tbl[5] = '{1'b0, 8'h00, 8'h13, 8'h80, 8'h7E, 8'hED, 1'b1, 4'b1000, 8'h06};
`endif

        tick(3);
        check_reset_outputs("reset");
        reset = 1'b1;
        tick(2);

        for (int i = 0; i < NV; i++) apply_vec(tbl[i]);

        // Partial frame abandoned after the idle timeout, then a full frame
        n0 = wr_log.size();
        t0 = tx_log.size();
        send_byte(8'h11, 1, 1);
        send_byte(8'h05, 1, 1);
        tick(int'(TMO) + 4);
        check("timeout_idle", 32'(busy), 0);
        check("timeout_no_wr", 32'(wr_log.size()), 32'(n0));
        check("timeout_no_tx", 32'(tx_log.size()), 32'(t0));
        apply_vec(tbl[4]);

        // Transmitter busy: response waits, byte during ACK sets overrun
        Tx_busy = 1'b1;
        n0 = wr_log.size();
        t0 = tx_log.size();
        send_frame(8'h12, 8'h03, 8'hA5);
        send_byte(8'h10, 1, 1);
        tick(20);
        check("busy_tx_held", 32'(tx_log.size()), 32'(t0));
        check("busy_wr_once", 32'(wr_log.size()), 32'(n0 + 1));
        check("busy_state", 32'(busy), 1);
        check("overrun_set", 32'(overrun), 1);
        Tx_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (Tx_start) begin
                seen = 1'b1;
                check("busy_ack_data", 32'(Tx_data), 32'h06);
            end
        end
        check("busy_ack_seen", 32'(seen), 1);
        tick(2);
        check("busy_idle_after", 32'(busy), 0);
        apply_vec(tbl[0]);
        check("overrun_sticky", 32'(overrun), 1);

        // Reset mid-frame discards the frame and clears everything
        send_byte(8'h13, 1, 1);
        send_byte(8'h07, 1, 1);
        n0 = wr_log.size();
        t0 = tx_log.size();
        reset = 1'b0;
        tick(1);
        check_reset_outputs("midreset");
        reset = 1'b1;
        tick(1);
        send_byte(8'h55, 1, 1);
        tick(3);
        check("midreset_no_wr", 32'(wr_log.size()), 32'(n0));
        check("midreset_no_tx", 32'(tx_log.size()), 32'(t0));
        apply_vec(tbl[2]);

        // Model-checked stream: exact-timeout gap, timeout+1 gap, then random
        wr_log.delete();
        tx_log.delete();
        gap_since = 1000;
        mbyte(8'h11, 1, int'(TMO) - 1);
        mbyte(8'h22, 1, int'(TMO) - 1);
`ifdef CMD_CHECKSUM_EN
        mbyte(8'h33, 1, int'(TMO) - 1);
        mbyte(8'h11 ^ 8'h22 ^ 8'h33, 1, 2);
`else
        mbyte(8'h33, 1, 2);
`endif
        mbyte(8'h12, 1, int'(TMO));
        mbyte(8'h44, 1, 2);
        for (int i = 0; i < 300; i++) begin
            if (mf.size() == 3 && $urandom_range(0, 9) < 7)
                b = mf[0] ^ mf[1] ^ mf[2];
            else if ($urandom_range(0, 1) == 1)
                b = IDB + 8'($urandom_range(0, N_MOD - 1));
            else
                b = 8'($urandom);
            mbyte(b, 1 + int'($urandom_range(0, 2)),
                  ($urandom_range(0, 9) == 0) ? int'(TMO) - 2 + int'($urandom_range(0, 3))
                                              : 1 + int'($urandom_range(0, 3)));
        end
        tick(int'(TMO) + 10);
        check("rand_wr_count", 32'(wr_log.size()), 32'(exp_wr_q.size()));
        check("rand_tx_count", 32'(tx_log.size()), 32'(exp_tx_q.size()));
        for (int i = 0; i < exp_wr_q.size() && i < wr_log.size(); i++) begin
            check("rand_wr_sel", 32'(wr_log[i].sel), 32'(exp_wr_q[i].sel));
            check("rand_wr_addr", 32'(wr_log[i].addr), 32'(exp_wr_q[i].addr));
            check("rand_wr_data", 32'(wr_log[i].data), 32'(exp_wr_q[i].data));
        end
        for (int i = 0; i < exp_tx_q.size() && i < tx_log.size(); i++)
            check("rand_tx_data", 32'(tx_log[i]), 32'(exp_tx_q[i]));
        check("rand_no_overrun", 32'(overrun), 0);
        check("wr_sel_zero_without_wr_en", 32'(sel_glitch), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
